// File: rtl/lsq_pkg.sv
// Shared types for the load/store queue.
// Issue FSM states, entry layout and access-size encodings.
package lsq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RESP  = 2'd2,
    STALL = 2'd3
  } lsq_state_e;

  localparam logic SIZE_WORD = 1'b0;
  localparam logic SIZE_BYTE = 1'b1;

  localparam int XLEN = 32;

  typedef struct packed {
    logic            valid;
    logic            is_store;
    logic            size;
    logic            addr_rdy;
    logic            committed;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
  } lsq_entry_t;

endpackage

// File: rtl/lsq_issue_fsm.sv
// Head-of-queue issue engine for the load/store queue.
// Sequences Cache requests, miss back-off and load completion.
module lsq_issue_fsm
  import lsq_pkg::*;
#(
  parameter int TAG_W     = 6,
  parameter int MISS_WAIT = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             head_ok,
  input  logic             head_is_store,
  input  logic             head_size,
  input  logic [31:0]      head_pc,
  input  logic [31:0]      head_addr,
  input  logic [31:0]      head_data,
  input  logic [TAG_W-1:0] head_tag,
  input  logic             cacheMiss,
  input  logic [31:0]      lw_data,
  output logic [31:0]      PC_out,
  output logic [31:0]      address_out,
  output logic [31:0]      data_sw,
  output logic             memRead,
  output logic             memWrite,
  output logic             storeSize,
  output logic             fromLSQ,
  output logic             pop,
  output logic             ld_done_valid,
  output logic [TAG_W-1:0] ld_done_tag,
  output logic [31:0]      ld_done_data
);

  localparam int CNT_W = $clog2(MISS_WAIT + 1);

  lsq_state_e state;
  lsq_state_e state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic drive;
  logic ld_pop;

  // Next state, stall counter and pop decision
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (head_ok) state_nxt = REQ;
      end
      REQ: begin
        state_nxt = RESP;
      end
      RESP: begin
        if (cacheMiss) begin
          state_nxt = STALL;
          cnt_nxt   = CNT_W'(MISS_WAIT);
        end else begin
          pop       = 1'b1;
          state_nxt = IDLE;
        end
      end
      STALL: begin
        cnt_nxt = cnt - 1'b1;
        if (cnt <= CNT_W'(1)) state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign drive  = (state == REQ) || (state == RESP);
  assign ld_pop = pop & ~head_is_store;

  assign PC_out      = drive ? head_pc   : '0;
  assign address_out = drive ? head_addr : '0;
  assign data_sw     = drive ? head_data : '0;
  assign memRead     = drive & ~head_is_store;
  assign memWrite    = drive & head_is_store;
  assign fromLSQ     = drive;
  assign storeSize   = (drive && head_size == SIZE_BYTE) ? SIZE_BYTE : SIZE_WORD;

  // State register and miss back-off counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Registered load completion pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ld_done_valid <= 1'b0;
      ld_done_tag   <= '0;
      ld_done_data  <= '0;
    end else if (flush) begin
      ld_done_valid <= 1'b0;
    end else begin
      ld_done_valid <= ld_pop;
      if (ld_pop) begin
        ld_done_tag  <= head_tag;
        ld_done_data <= lw_data;
      end
    end
  end

endmodule

// File: rtl/load_store_queue.sv
// In-order load/store queue between dispatch/AGU and the data Cache.
// Stores wait for ROB commit; one op issues at a time from the head.
module load_store_queue
  import lsq_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int IDX_W     = 3,
  parameter int TAG_W     = 6,
  parameter int MISS_WAIT = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             alloc_valid,
  input  logic             alloc_is_store,
  input  logic             alloc_size,
  input  logic [31:0]      alloc_pc,
  input  logic [TAG_W-1:0] alloc_tag,
  output logic [IDX_W-1:0] alloc_idx,
  output logic             full,
  input  logic             agu_valid,
  input  logic [IDX_W-1:0] agu_idx,
  input  logic [31:0]      agu_addr,
  input  logic [31:0]      agu_data,
  input  logic             commit_valid,
  input  logic [TAG_W-1:0] commit_tag,
  input  logic             flush,
  output logic [31:0]      PC_out,
  output logic [31:0]      address_out,
  output logic [31:0]      data_sw,
  output logic             memRead,
  output logic             memWrite,
  output logic             storeSize,
  output logic             fromLSQ,
  input  logic [31:0]      lw_data,
  input  logic             cacheMiss,
  output logic             ld_done_valid,
  output logic [TAG_W-1:0] ld_done_tag,
  output logic [31:0]      ld_done_data
);

  lsq_entry_t       q     [DEPTH];
  logic [TAG_W-1:0] tag_q [DEPTH];

  logic [IDX_W:0]   head;
  logic [IDX_W:0]   tail;
  logic [IDX_W:0]   count;
  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] tail_idx;
  lsq_entry_t       h;
  logic             head_ok;
  logic             do_alloc;
  logic             pop;

  assign head_idx  = head[IDX_W-1:0];
  assign tail_idx  = tail[IDX_W-1:0];
  assign count     = tail - head;
  assign full      = (count == (IDX_W+1)'(DEPTH));
  assign alloc_idx = tail_idx;
  assign do_alloc  = alloc_valid & ~full;

  assign h       = q[head_idx];
  assign head_ok = h.valid & h.addr_rdy & (~h.is_store | h.committed);

  // Entry storage and circular pointers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q[i]     <= '0;
        tag_q[i] <= '0;
      end
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q[i].valid <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (agu_valid && agu_idx == IDX_W'(i) && q[i].valid) begin
          q[i].addr     <= agu_addr;
          q[i].data     <= agu_data;
          q[i].addr_rdy <= 1'b1;
        end
        if (commit_valid && q[i].valid && q[i].is_store &&
            tag_q[i] == commit_tag) begin
          q[i].committed <= 1'b1;
        end
        if (pop && head_idx == IDX_W'(i)) begin
          q[i].valid <= 1'b0;
        end
        if (do_alloc && tail_idx == IDX_W'(i)) begin
          q[i].valid     <= 1'b1;
          q[i].is_store  <= alloc_is_store;
          q[i].size      <= alloc_size;
          q[i].addr_rdy  <= 1'b0;
          q[i].committed <= 1'b0;
          q[i].pc        <= alloc_pc;
          tag_q[i]       <= alloc_tag;
        end
      end
      head <= head + {{IDX_W{1'b0}}, pop};
      tail <= tail + {{IDX_W{1'b0}}, do_alloc};
    end
  end

  lsq_issue_fsm #(
    .TAG_W     (TAG_W),
    .MISS_WAIT (MISS_WAIT)
  ) u_issue (
    .clk           (clk),
    .rstn          (rstn),
    .flush         (flush),
    .head_ok       (head_ok),
    .head_is_store (h.is_store),
    .head_size     (h.size),
    .head_pc       (h.pc),
    .head_addr     (h.addr),
    .head_data     (h.data),
    .head_tag      (tag_q[head_idx]),
    .cacheMiss     (cacheMiss),
    .lw_data       (lw_data),
    .PC_out        (PC_out),
    .address_out   (address_out),
    .data_sw       (data_sw),
    .memRead       (memRead),
    .memWrite      (memWrite),
    .storeSize     (storeSize),
    .fromLSQ       (fromLSQ),
    .pop           (pop),
    .ld_done_valid (ld_done_valid),
    .ld_done_tag   (ld_done_tag),
    .ld_done_data  (ld_done_data)
  );

endmodule
